// File: rtl/count_sequencer_if.sv
// Command and status bundle between the switch decode and count_sequencer.
// The master drives commands and limits; the slave returns count and status.
interface count_sequencer_if #(
  parameter int NBITS = 4
);
  logic             start;
  logic             stop;
  logic             clear;
  logic             load;
  logic [NBITS-1:0] load_value;
  logic [1:0]       mode;
  logic [NBITS-1:0] lo_lim;
  logic [NBITS-1:0] hi_lim;
  logic [NBITS-1:0] count;
  logic             dir;
  logic             step;
  logic [1:0]       state;
  logic             at_limit;

  modport master (
    output start, stop, clear, load,
    output load_value, mode, lo_lim, hi_lim,
    input  count, dir, step, state, at_limit
  );

  modport slave (
    input  start, stop, clear, load,
    input  load_value, mode, lo_lim, hi_lim,
    output count, dir, step, state, at_limit
  );
endinterface

// File: rtl/count_sequencer.sv
// Run-control and mode sequencer for the counter datapath:
// gated, prescaled up/down/bounce/hold stepping between limits.
module count_sequencer #(
  parameter int NBITS    = 4,
  parameter int PRESCALE = 1
) (
  input logic            clk_2,
  input logic            reset,
  count_sequencer_if.slave bus
);
  localparam int PW = $clog2(PRESCALE + 1);
  localparam logic [PW-1:0] PLAST = PW'(PRESCALE - 1);

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] RUN    = 2'b01;
  localparam logic [1:0] PAUSED = 2'b10;

  logic [PW-1:0]    pre;
  logic             tick;
  logic [NBITS-1:0] inc;
  logic [NBITS-1:0] dec;
  logic [NBITS-1:0] bnc;
  logic [NBITS-1:0] nxt_count;
  logic             nxt_dir;

  assign tick = (bus.state == RUN) && (pre == PLAST);
  assign inc  = bus.count + NBITS'(1);
  assign dec  = bus.count - NBITS'(1);
  assign bnc  = bus.dir ? dec : inc;

  assign bus.at_limit = (bus.count == bus.lo_lim) ||
                        (bus.count == bus.hi_lim);

  always_comb begin
    nxt_count = bus.count;
    nxt_dir   = bus.dir;
    if (bus.lo_lim >= bus.hi_lim) begin
      nxt_count = bus.lo_lim;
    end else begin
      case (bus.mode)
        2'b00: begin
          nxt_dir = 1'b0;
          if (bus.count >= bus.hi_lim ||
              bus.count <  bus.lo_lim)
            nxt_count = bus.lo_lim;
          else
            nxt_count = inc;
        end
        2'b01: begin
          nxt_dir = 1'b1;
          if (bus.count <= bus.lo_lim ||
              bus.count >  bus.hi_lim)
            nxt_count = bus.hi_lim;
          else
            nxt_count = dec;
        end
        2'b10: begin
          if (bus.count < bus.lo_lim ||
              bus.count > bus.hi_lim) begin
            nxt_count = bus.lo_lim;
            nxt_dir   = 1'b0;
          end else begin
            nxt_count = bnc;
            if (bnc == bus.hi_lim)
              nxt_dir = 1'b1;
            else if (bnc == bus.lo_lim)
              nxt_dir = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Start while already running is a no-op and lets the tick through.
  always_ff @(posedge clk_2) begin
    if (reset) begin
      bus.count <= '0;
      bus.dir   <= 1'b0;
      bus.state <= IDLE;
      bus.step  <= 1'b0;
      pre       <= '0;
    end else begin
      bus.step <= 1'b0;
      if (bus.clear) begin
        bus.state <= IDLE;
        bus.count <= '0;
        bus.dir   <= 1'b0;
        pre       <= '0;
      end else if (bus.load) begin
        bus.count <= bus.load_value;
        pre       <= '0;
      end else if (bus.stop) begin
        if (bus.state == RUN)
          bus.state <= PAUSED;
      end else if (bus.start && bus.state != RUN) begin
        if (bus.state == IDLE)
          pre <= '0;
        bus.state <= RUN;
      end else if (bus.state == RUN) begin
        if (tick) begin
          pre       <= '0;
          bus.count <= nxt_count;
          bus.dir   <= nxt_dir;
          bus.step  <= 1'b1;
        end else begin
          pre <= pre + PW'(1);
        end
      end
    end
  end
endmodule
